// File: rtl/req_gnt_arbiter.sv
// Round-robin request/grant arbiter with a bounded hold time per grant.
// A grant ends on request drop or on MAX_HOLD expiry. Every release inserts one idle cycle.
module req_gnt_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       preempt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HCW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
  localparam logic [HCW:0]   RUN_MAX  = (HCW + 1)'(MAX_HOLD);

  logic [0:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDW-1:0]     r_gnt_id;
  logic [IDW-1:0]     r_last;
  logic [HCW-1:0]     r_hold_cnt;
  logic               r_preempt;
  logic [HCW:0]       r_run;

  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_idx;
  logic               w_any_req;
  logic               w_owner_req;

  // The search runs from the farthest offset down to the nearest one.
  // The last match written is therefore the first asserted requester after r_last.
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = IDW'((int'(r_last) + off) % NUM_REQ);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_any_req   = |req;
  assign w_owner_req = req[r_gnt_id];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_last     <= LAST_RST;
      r_hold_cnt <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state    <= GRANT;
            r_gnt      <= NUM_REQ'(1) << w_winner;
            r_gnt_id   <= w_winner;
            r_hold_cnt <= HCW'(1);
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_last     <= r_gnt_id;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt < HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + HCW'(1);
          end else begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_last     <= r_gnt_id;
            r_hold_cnt <= '0;
            r_preempt  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state == GRANT);
  assign preempt = r_preempt;

  // Independent count of consecutive granted cycles, used only by the hold-time property.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= '0;
    end else if (r_gnt == '0) begin
      r_run <= '0;
    end else if (r_run <= RUN_MAX) begin
      r_run <= r_run + (HCW + 1)'(1);
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(r_gnt));

  a_hold_limit: assert property (@(posedge clk) disable iff (!reset_n) r_run <= RUN_MAX);

  a_preempt_release: assert property (@(posedge clk) disable iff (!reset_n)
    r_preempt |-> (($past(r_gnt) != '0) && (r_gnt == '0)));

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rise_chk
    a_rise_needs_req: assert property (@(posedge clk) disable iff (!reset_n)
      $rose(r_gnt[i]) |-> $past(req[i]));
  end

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed bench for req_gnt_arbiter.
// Instance A is the default build (NUM_REQ=4, MAX_HOLD=8); instance B uses MAX_HOLD=1.
module tb_req_gnt_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] reqA, gntA, reqB, gntB;
  logic [1:0] gntIdA, gntIdB;
  logic       busyA, preemptA, busyB, preemptB;
  int         errorCount = 0;
  int         checkCount = 0;

  always #5 clk = ~clk;

  req_gnt_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dutA (
    .clk(clk), .reset_n(reset_n), .req(reqA), .gnt(gntA),
    .gnt_id(gntIdA), .busy(busyA), .preempt(preemptA)
  );

  req_gnt_arbiter #(.NUM_REQ(4), .MAX_HOLD(1)) dutB (
    .clk(clk), .reset_n(reset_n), .req(reqB), .gnt(gntB),
    .gnt_id(gntIdB), .busy(busyB), .preempt(preemptB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] newReq, input int cycles);
    reqA = newReq;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulseReset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    reqA    = 4'b0000;
    reqB    = 4'b0000;
    repeat (2) @(negedge clk);
    checkOutput("reset gnt", gntA, 4'b0000);
    checkOutput("reset gnt_id", gntIdA, 2'd0);
    checkOutput("reset busy", busyA, 1'b0);
    checkOutput("reset preempt", preemptA, 1'b0);
    checkOutput("reset gntB", gntB, 4'b0000);
    reset_n = 1'b1;

    $display("[TB] single requester, voluntary release");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0100, 1);
      checkOutput("s1 gnt", gntA, 4'b0100);
      checkOutput("s1 preempt", preemptA, 1'b0);
    end
    checkOutput("s1 gnt_id", gntIdA, 2'd2);
    checkOutput("s1 busy", busyA, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("s1 release gnt", gntA, 4'b0000);
    checkOutput("s1 release busy", busyA, 1'b0);
    checkOutput("s1 release preempt", preemptA, 1'b0);

    $display("[TB] all requesters, rotation with preemption");
    pulseReset();
    reqA = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        checkOutput("s2 gnt", gntA, 4'b0001 << (g % 4));
        if (k == 0) begin
          checkOutput("s2 gnt_id", gntIdA, g % 4);
          checkOutput("s2 preempt low", preemptA, 1'b0);
        end
      end
      @(negedge clk);
      checkOutput("s2 gap gnt", gntA, 4'b0000);
      checkOutput("s2 gap preempt", preemptA, 1'b1);
    end
    applyStimulus(4'b0000, 1);
    checkOutput("s2 idle gnt", gntA, 4'b0000);
    checkOutput("s2 idle preempt", preemptA, 1'b0);

    $display("[TB] owner drops early, then non-owner pulses");
    pulseReset();
    applyStimulus(4'b0011, 1);
    checkOutput("s3 gnt0 c1", gntA, 4'b0001);
    applyStimulus(4'b0011, 1);
    checkOutput("s3 gnt0 c2", gntA, 4'b0001);
    applyStimulus(4'b0010, 1);
    checkOutput("s3 gap gnt", gntA, 4'b0000);
    checkOutput("s3 gap preempt", preemptA, 1'b0);
    applyStimulus(4'b0010, 1);
    checkOutput("s3 gnt1", gntA, 4'b0010);
    checkOutput("s3 gnt1 id", gntIdA, 2'd1);
    applyStimulus(4'b0110, 1);
    checkOutput("s4 pulse gnt", gntA, 4'b0010);
    applyStimulus(4'b0010, 1);
    checkOutput("s4 after pulse gnt", gntA, 4'b0010);
    applyStimulus(4'b0000, 1);
    checkOutput("s4 release gnt", gntA, 4'b0000);
    checkOutput("s4 release preempt", preemptA, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("s4 no late grant", gntA, 4'b0000);
    applyStimulus(4'b0101, 1);
    checkOutput("s4 rotate gnt", gntA, 4'b0100);
    checkOutput("s4 rotate id", gntIdA, 2'd2);
    applyStimulus(4'b0000, 1);
    checkOutput("s4 end gnt", gntA, 4'b0000);

    $display("[TB] reset during a grant");
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0001, 1);
      checkOutput("s5 gnt", gntA, 4'b0001);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("s5 async gnt", gntA, 4'b0000);
    checkOutput("s5 async busy", busyA, 1'b0);
    checkOutput("s5 async preempt", preemptA, 1'b0);
    checkOutput("s5 async gnt_id", gntIdA, 2'd0);
    reqA = 4'b1000;
    @(negedge clk);
    checkOutput("s5 held gnt", gntA, 4'b0000);
    @(negedge clk);
    checkOutput("s5 held gnt 2", gntA, 4'b0000);
    checkOutput("s5 held preempt", preemptA, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("s5 post reset gnt", gntA, 4'b1000);
    checkOutput("s5 post reset id", gntIdA, 2'd3);
    applyStimulus(4'b0000, 1);
    checkOutput("s5 end gnt", gntA, 4'b0000);

    $display("[TB] MAX_HOLD=1 build");
    reqB = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("s6 gntB on", gntB, 4'b0001);
      checkOutput("s6 preemptB low", preemptB, 1'b0);
      @(negedge clk);
      checkOutput("s6 gntB off", gntB, 4'b0000);
      checkOutput("s6 preemptB high", preemptB, 1'b1);
    end
    reqB = 4'b0000;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
